hilo_mult_unit: RTL

//   Iterative shift-add multiplier that owns the HI/LO register pair. It is the

---
 rtl/hilo_mult_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit: iterative shift-add multiplier that owns the HI/LO pair.
//
// A start strobe (HLwrite) captures a and b, then the unit runs WIDTH
// shift-add iterations and commits the 2*WIDTH-bit product to HI (upper
// half) and LO (lower half) on the same edge that raises done. HI/LO keep
// their previous value while the multiply is in flight. A start that
// arrives while busy is dropped. A start seen in the DONE cycle is accepted
// immediately, so back-to-back multiplies run at one per WIDTH+1 cycles.
//
// Optional feature macro: SIGNED_MULT_EN
//   defined   -> is_signed=1 selects signed (mult) arithmetic through
//                magnitude conversion and a final negate; latency is unchanged.
//   undefined -> every operation is unsigned (multu); is_signed is ignored.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts a multiply, clears HI/LO)
//   start      request a multiply of a*b
//   is_signed  1 = mult, 0 = multu
//   a, b       multiplicand / multiplier
//   hl_sel     1 selects HI onto hl_out, 0 selects LO
//   busy       high while iterating
//   done       one-cycle pulse, HI/LO updated on the same edge
//   hi, lo     product registers
//   hl_out     hl_sel ? hi : lo
module hilo_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hl_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hl_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc_hi;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  logic               start_ok;
  logic [WIDTH-1:0]   add_val;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_hi_nxt;
  logic [WIDTH-1:0]   mplier_nxt;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   a_load;
  logic [WIDTH-1:0]   b_load;
  logic               neg_load;

  // Absolute value of a two's-complement operand. The most negative value
  // maps onto itself, which is still the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] m;
    m = v[WIDTH-1] ? -v : v;
    return m;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_product(input logic [2*WIDTH-1:0] p);
    return ~p + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Operand conditioning at start time.
`ifdef SIGNED_MULT_EN
  always_comb begin
    if (is_signed) begin
      a_load   = magnitude(a);
      b_load   = magnitude(b);
      neg_load = a[WIDTH-1] ^ b[WIDTH-1];
    end else begin
      a_load   = a;
      b_load   = b;
      neg_load = 1'b0;
    end
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign a_load           = a;
  assign b_load           = b;
  assign neg_load         = 1'b0;
`endif

  assign start_ok = start && (state == S_IDLE || state == S_DONE);

  // One shift-add step: the add keeps its carry in sum[WIDTH], and the
  // whole {carry, acc_hi, mplier} chain then moves right by one bit.
  always_comb begin
    add_val    = mplier[0] ? mcand : '0;
    sum        = {1'b0, acc_hi} + {1'b0, add_val};
    acc_hi_nxt = sum[WIDTH:1];
    mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
    product    = {acc_hi_nxt, mplier_nxt};
    result     = neg ? negate_product(product) : product;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            mcand  <= a_load;
            mplier <= b_load;
            neg    <= neg_load;
            acc_hi <= '0;
            cnt    <= CNT_W'(WIDTH);
            state  <= S_BUSY;
            busy   <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_BUSY: begin
          acc_hi <= acc_hi_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt - CNT_W'(1);
          // Last iteration: commit the finished product on the DONE entry edge.
          if (cnt == CNT_W'(1)) begin
            hi    <= result[2*WIDTH-1:WIDTH];
            lo    <= result[WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hl_out = hl_sel ? hi : lo;

endmodule
